// File: rtl/mult_result_checker.sv
// Response-side checker for a locked 8x8 multiplier: computes the golden product with a
// sequential shift-add multiplier, flags mismatches and tracks per-sweep error counts.
module mult_result_checker #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 vec_valid_i,
    output logic                 vec_ready_o,
    input  logic [WIDTH-1:0]     operand1_i,
    input  logic [WIDTH-1:0]     operand2_i,
    input  logic [2*WIDTH-1:0]   result_i,
    input  logic                 last_i,
    output logic                 chk_valid_o,
    output logic                 mismatch_o,
    output logic [2*WIDTH-1:0]   expected_o,
    output logic [CNT_W-1:0]     err_count_o,
    output logic                 sweep_done_o,
    output logic                 key_pass_o
);

    localparam int PW     = 2 * WIDTH;
    localparam int STEP_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        RESP
    } state_t;

    state_t              state, state_nxt;
    logic [STEP_W-1:0]   step;
    logic [WIDTH-1:0]    op1_q, op2_q;
    logic [PW-1:0]       res_q;
    logic [PW-1:0]       acc_q;
    logic [PW-1:0]       acc_nxt;
    logic                last_q;
    logic                first_q;
    logic                sweep_start;
    logic                accept;
    logic                final_step;
    logic                mm_nxt;
    logic [CNT_W-1:0]    cnt_base;
    logic [CNT_W-1:0]    cnt_nxt;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] base, input logic inc);
        if (inc && (base != {CNT_W{1'b1}}))
            return base + CNT_W'(1);
        return base;
    endfunction

    function automatic logic [PW-1:0] partial(input logic [WIDTH-1:0] mcand, input logic sel,
                                              input logic [STEP_W-1:0] sh);
        return sel ? (PW'(mcand) << sh) : '0;
    endfunction

    assign accept     = vec_valid_i & vec_ready_o;
    assign final_step = (state == MUL) && (step == STEP_W'(WIDTH - 1));
    assign acc_nxt    = acc_q + partial(op1_q, op2_q[step], step);
    assign mm_nxt     = (res_q != acc_nxt);
    assign cnt_base   = first_q ? '0 : err_count_o;
    assign cnt_nxt    = sat_inc(cnt_base, mm_nxt);

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = MUL;
            MUL:     if (final_step) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control and visible outputs; reset clears everything the outside world can see.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vec_ready_o  <= 1'b0;
            chk_valid_o  <= 1'b0;
            sweep_done_o <= 1'b0;
            mismatch_o   <= 1'b0;
            expected_o   <= '0;
            err_count_o  <= '0;
            key_pass_o   <= 1'b0;
            sweep_start  <= 1'b1;
            first_q      <= 1'b0;
            step         <= '0;
        end else begin
            vec_ready_o  <= (state_nxt == IDLE);
            chk_valid_o  <= final_step;
            sweep_done_o <= final_step & last_q;
            if (accept) begin
                step        <= '0;
                first_q     <= sweep_start;
                sweep_start <= 1'b0;
                key_pass_o  <= 1'b0;
            end else if (state == MUL) begin
                step <= step + STEP_W'(1);
            end
            if (final_step) begin
                expected_o  <= acc_nxt;
                mismatch_o  <= mm_nxt;
                err_count_o <= cnt_nxt;
                if (last_q) begin
                    key_pass_o  <= (cnt_nxt == '0);
                    sweep_start <= 1'b1;
                end
            end
        end
    end

    // Datapath: operands captured at acceptance, accumulator cleared then built up one bit per cycle.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            op1_q  <= operand1_i;
            op2_q  <= operand2_i;
            res_q  <= result_i;
            last_q <= last_i;
            acc_q  <= '0;
        end else if (state == MUL) begin
            acc_q <= acc_nxt;
        end
    end

endmodule

// File: tb/tb_mult_result_checker.sv
// Directed and randomized bench for mult_result_checker, checked against a plain-arithmetic model.
module tb_mult_result_checker;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst_i;
    logic                vec_valid_i;
    logic                vec_ready_o;
    logic [WIDTH-1:0]    operand1_i;
    logic [WIDTH-1:0]    operand2_i;
    logic [2*WIDTH-1:0]  result_i;
    logic                last_i;
    logic                chk_valid_o;
    logic                mismatch_o;
    logic [2*WIDTH-1:0]  expected_o;
    logic [CNT_W-1:0]    err_count_o;
    logic                sweep_done_o;
    logic                key_pass_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int hs_cyc   = 0;

    // Reference model state: errors so far in the sweep and whether the next vector starts a sweep.
    int model_cnt   = 0;
    bit model_first = 1'b1;
    logic [15:0] last_exp;

    mult_result_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .vec_valid_i  (vec_valid_i),
        .vec_ready_o  (vec_ready_o),
        .operand1_i   (operand1_i),
        .operand2_i   (operand2_i),
        .result_i     (result_i),
        .last_i       (last_i),
        .chk_valid_o  (chk_valid_o),
        .mismatch_o   (mismatch_o),
        .expected_o   (expected_o),
        .err_count_o  (err_count_o),
        .sweep_done_o (sweep_done_o),
        .key_pass_o   (key_pass_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        operand1_i = 8'($urandom);
        operand2_i = 8'($urandom);
        result_i   = 16'($urandom);
        last_i     = 1'($urandom);
    endtask

    task automatic do_vec(input logic [7:0] a, input logic [7:0] b, input logic [15:0] r,
                          input logic l, input bit hold, input string tag);
        int k;
        int prod;
        bit mm;
        int base;
        k = 0;
        @(negedge clk);
        while (!vec_ready_o && k < 40) begin
            if (hold) scramble();
            @(negedge clk);
            k++;
        end
        check({tag, "_ready"}, 32'(vec_ready_o), 32'd1);
        operand1_i  = a;
        operand2_i  = b;
        result_i    = r;
        last_i      = l;
        vec_valid_i = 1'b1;
        @(posedge clk);
        #1;
        hs_cyc = cyc;
        if (!hold) vec_valid_i = 1'b0;
        scramble();
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                check({tag, "_busy"}, 32'(vec_ready_o), 32'd0);
                check({tag, "_kp_clr"}, 32'(key_pass_o), 32'd0);
            end
            if (hold && !chk_valid_o) scramble();
        end while (!chk_valid_o && k < 20);
        check({tag, "_latency"}, 32'(k), 32'd9);

        prod = int'(a) * int'(b);
        mm   = (int'(r) != prod);
        base = model_first ? 0 : model_cnt;
        model_first = 1'b0;
        model_cnt   = (base + int'(mm) > SAT) ? SAT : base + int'(mm);
        if (l) model_first = 1'b1;
        last_exp = 16'(prod);

        check({tag, "_expected"}, 32'(expected_o), 32'(prod));
        check({tag, "_mismatch"}, 32'(mismatch_o), 32'(mm));
        check({tag, "_count"}, 32'(err_count_o), 32'(model_cnt));
        check({tag, "_sweep_done"}, 32'(sweep_done_o), 32'(l));
        check({tag, "_key_pass"}, 32'(key_pass_o), 32'(l && model_cnt == 0));
    endtask

    initial begin
        int prev_hs;
        int pulses;
        logic [7:0] ra, rb;
        rst_i       = 1'b1;
        vec_valid_i = 1'b0;
        operand1_i  = '0;
        operand2_i  = '0;
        result_i    = '0;
        last_i      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {vec_ready_o, chk_valid_o, mismatch_o, expected_o, err_count_o, sweep_done_o, key_pass_o},
              32'd0);
        rst_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_reset", 32'(vec_ready_o), 32'd1);

        // T1: single-vector sweep
        do_vec(8'h29, 8'h7A, 16'h138A, 1'b1, 1'b0, "t1");
        repeat (3) @(negedge clk);
        check("t1_hold_expected", 32'(expected_o), 32'(last_exp));
        check("t1_hold_key_pass", 32'(key_pass_o), 32'd1);
        check("t1_no_pulse", 32'(chk_valid_o), 32'd0);

        // T2: correct key sweep
        do_vec(8'h89, 8'hFF, 16'h8877, 1'b0, 1'b0, "t2a");
        do_vec(8'h80, 8'h80, 16'h4000, 1'b0, 1'b0, "t2b");
        do_vec(8'hFA, 8'h00, 16'h0000, 1'b1, 1'b0, "t2c");

        // T3: wrong key
        do_vec(8'h89, 8'hFF, 16'h8876, 1'b0, 1'b0, "t3a");
        do_vec(8'h80, 8'h80, 16'h4000, 1'b0, 1'b0, "t3b");
        do_vec(8'hFA, 8'h00, 16'h0001, 1'b1, 1'b0, "t3c");

        // T4: count restarts on a new sweep
        do_vec(8'h24, 8'h92, 16'h1488, 1'b1, 1'b0, "t4");

        // T5: valid held high throughout
        do_vec(8'h55, 8'hAA, 16'h3872, 1'b0, 1'b1, "t5a");
        prev_hs = hs_cyc;
        do_vec(8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b1, "t5b");
        check("t5_period_b", 32'(hs_cyc - prev_hs), 32'(WIDTH + 2));
        prev_hs = hs_cyc;
        do_vec(8'h01, 8'hFF, 16'h00FF, 1'b1, 1'b1, "t5c");
        check("t5_period_c", 32'(hs_cyc - prev_hs), 32'(WIDTH + 2));
        vec_valid_i = 1'b0;

        // Randomized sweep, roughly a third of the results corrupted
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            do_vec(ra, rb, 16'(int'(ra) * int'(rb)) ^ (($urandom_range(0, 2) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0),
                   (i == 7), 1'b0, "rand");
        end

        // T6: reset during MUL step 4
        do_vec(8'h12, 8'h34, 16'hFFFF, 1'b0, 1'b0, "t6_pre");
        @(negedge clk);
        operand1_i  = 8'h33;
        operand2_i  = 8'h77;
        result_i    = 16'h0;
        last_i      = 1'b0;
        vec_valid_i = 1'b1;
        @(posedge clk);
        #1;
        vec_valid_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        pulses = 0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            if (chk_valid_o) pulses++;
            check("t6_reset_outputs",
                  {vec_ready_o, chk_valid_o, mismatch_o, expected_o, err_count_o, sweep_done_o, key_pass_o},
                  32'd0);
        end
        rst_i = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (chk_valid_o) pulses++;
        end
        check("t6_no_pulse", 32'(pulses), 32'd0);
        model_cnt   = 0;
        model_first = 1'b1;

        // Saturation: more mismatches than the counter can hold
        for (int i = 0; i < SAT + 2; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            do_vec(ra, rb, ~16'(int'(ra) * int'(rb)), (i == SAT + 1), 1'b0, "sat");
        end
        check("sat_final", 32'(err_count_o), 32'(SAT));

        // Fresh sweep after reset/saturation starts from 0
        do_vec(8'h0F, 8'h0F, 16'h00E1, 1'b1, 1'b0, "after_sat");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
